// File: rtl/seq101_pkg.sv
// Shared encodings for the "101" pattern scanner: pattern states and
// the word-level control states.
package seq101_pkg;

    typedef enum logic [1:0] {
        PAT_A = 2'b00,
        PAT_B = 2'b01,
        PAT_C = 2'b10,
        PAT_D = 2'b11
    } pat_state_e;

    typedef enum logic [1:0] {
        CTRL_IDLE = 2'b00,
        CTRL_SCAN = 2'b01,
        CTRL_DONE = 2'b10
    } ctrl_state_e;

endpackage

// File: rtl/fsm_101_next.sv
// Combinational next-state and Moore output for the "101" pattern FSM.
// It holds no state; the caller owns the state register.
module fsm_101_next
    import seq101_pkg::*;
(
    input  logic       in,
    input  logic [1:0] state,
    output logic [1:0] next_state,
    output logic       out
);

    always_comb begin
        next_state = PAT_A;
        case (state)
            PAT_A:   next_state = in ? PAT_B : PAT_A;
            PAT_B:   next_state = in ? PAT_B : PAT_C;
            PAT_C:   next_state = in ? PAT_D : PAT_A;
            PAT_D:   next_state = in ? PAT_B : PAT_C;
            default: next_state = PAT_A;
        endcase
    end

    assign out = (state == PAT_D);

endmodule

// File: rtl/seq101_scan_ctrl.sv
// Word-level controller: accepts a word, feeds it MSB-first through the
// "101" next-state logic one bit per clock, and returns count/mask/state.
module seq101_scan_ctrl
    import seq101_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [WIDTH-1:0] out_mask,
    output logic [1:0]       out_state
);

    localparam int IDX_W = $clog2(WIDTH);

    ctrl_state_e      ctrl_q, ctrl_d;
    logic [1:0]       pat_q, pat_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [1:0]       pat_next;
    logic             unused_cur_is_d;

    fsm_101_next u_next (
        .in         (word_q[idx_q]),
        .state      (pat_q),
        .next_state (pat_next),
        .out        (unused_cur_is_d)
    );

    always_comb begin
        ctrl_d = ctrl_q;
        pat_d  = pat_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        mask_d = mask_q;
        word_d = word_q;
        case (ctrl_q)
            CTRL_IDLE: begin
                if (in_valid) begin
                    word_d = in_data;
                    idx_d  = IDX_W'(WIDTH - 1);
                    cnt_d  = '0;
                    mask_d = '0;
                    if (in_clear) pat_d = PAT_A;
                    ctrl_d = CTRL_SCAN;
                end
            end
            CTRL_SCAN: begin
                pat_d = pat_next;
                if (pat_next == PAT_D) begin
                    cnt_d         = cnt_q + CNT_W'(1);
                    mask_d[idx_q] = 1'b1;
                end
                if (idx_q == '0) ctrl_d = CTRL_DONE;
                else             idx_d  = idx_q - IDX_W'(1);
            end
            CTRL_DONE: begin
                if (out_ready) ctrl_d = CTRL_IDLE;
            end
            default: ctrl_d = CTRL_IDLE;
        endcase
    end

    // Reset must clear results immediately, so everything visible is async-reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_q <= CTRL_IDLE;
            pat_q  <= PAT_A;
            idx_q  <= '0;
            cnt_q  <= '0;
            mask_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            pat_q  <= pat_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            mask_q <= mask_d;
        end
    end

    // The word buffer is reloaded on every accept, so it needs no reset.
    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

    assign in_ready  = (ctrl_q == CTRL_IDLE);
    assign out_valid = (ctrl_q == CTRL_DONE);
    assign out_count = cnt_q;
    assign out_mask  = mask_q;
    assign out_state = pat_q;

endmodule

// File: tb/tb_seq101_scan_ctrl.sv
// Self-checking bench for seq101_scan_ctrl: directed, back-pressure, reset
// and exhaustive/random words compared against a transition-table model.
module tb_seq101_scan_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_clear = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_count;
    logic [W-1:0]  out_mask;
    logic [1:0]    out_state;

    int errors = 0;
    int checks = 0;

    // Reference: pattern state tracked as an integer, transitions by table.
    int     nxt_tbl [4][2] = '{'{0, 1}, '{2, 1}, '{0, 3}, '{2, 1}};
    int     mstate = 0;
    int     exp_cnt;
    int     exp_mask;
    logic [7:0] pre_word [4] = '{8'h00, 8'h01, 8'h02, 8'h05};

    seq101_scan_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_clear  (in_clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_mask  (out_mask),
        .out_state (out_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] d, input bit clr);
        exp_cnt  = 0;
        exp_mask = 0;
        if (clr) mstate = 0;
        for (int k = W - 1; k >= 0; k--) begin
            mstate = nxt_tbl[mstate][d[k]];
            if (mstate == 3) begin
                exp_cnt++;
                exp_mask = exp_mask | (1 << k);
            end
        end
    endfunction

    // Offer a word and return at the negedge after the accept edge.
    task automatic put(input logic [W-1:0] d, input bit clr);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_clear = clr;
        @(negedge clk);
        in_valid = 1'b0;
        model(d, clr);
    endtask

    task automatic wait_done(input string tag);
        int lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"},   lat, W);
        chk({tag, "_count"}, out_count, exp_cnt);
        chk({tag, "_mask"},  out_mask, exp_mask);
        chk({tag, "_state"}, out_state, mstate);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_vld_drop"}, out_valid, 0);
    endtask

    initial begin
        // Reset state
        #2 resetn = 1'b0;
        #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", out_count, 0);
        chk("rst_mask",  out_mask, 0);
        chk("rst_state", out_state, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Directed words
        put(8'b1010_1000, 1'b1);
        wait_done("d28");
        chk("d28_lit_count", out_count, 2);
        chk("d28_lit_mask",  out_mask, 8'h28);
        release_out("d28");
        put(8'hAA, 1'b1); wait_done("dAA"); release_out("dAA");
        put(8'hFF, 1'b1); wait_done("dFF"); release_out("dFF");
        put(8'h02, 1'b1); wait_done("d02"); release_out("d02");
        put(8'h80, 1'b0); wait_done("carry");
        chk("carry_lit_count", out_count, 1);
        chk("carry_lit_state", out_state, 0);
        release_out("carry");
        put(8'h80, 1'b1); wait_done("d80c"); release_out("d80c");

        // Back-pressure with a pending word
        put(8'h55, 1'b1);
        wait_done("bp");
        in_valid = 1'b1;
        in_data  = 8'hA5;
        in_clear = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_ready", in_ready, 0);
            chk("bp_count", out_count, exp_cnt);
            chk("bp_mask",  out_mask, exp_mask);
            chk("bp_state", out_state, mstate);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle_ready", in_ready, 1);
        chk("bp_idle_valid", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        model(8'hA5, 1'b0);
        chk("bp_accepted", in_ready, 0);
        wait_done("bp2");
        release_out("bp2");

        // Reset in the middle of a scan
        put(8'hAA, 1'b1);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_count", out_count, 0);
        chk("mid_rst_mask",  out_mask, 0);
        chk("mid_rst_state", out_state, 0);
        @(negedge clk);
        chk("mid_rst_hold", in_ready, 1);
        resetn = 1'b1;
        mstate = 0;
        @(negedge clk);
        put(8'h28, 1'b0); wait_done("post_rst"); release_out("post_rst");

        // Every word from every start state
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 256; w++) begin
                put(pre_word[s], 1'b1); wait_done("pre"); release_out("pre");
                put(w[7:0], 1'b0);      wait_done("exh"); release_out("exh");
            end
        end

        // Random words, random clear
        for (int i = 0; i < 300; i++) begin
            put(W'($urandom), ($urandom_range(0, 3) == 0));
            wait_done("rnd");
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("rnd_hold", out_valid, 1);
            end
            release_out("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
